strassen_mac2x2: RTL and testbench

- Parametrised, pipelined 2x2 signed matrix multiply-accumulate unit using the 7-product Strassen decomposition.
- Successor to the fixed-width 2x2 Strassen multiplier. Adds a valid/ready handshake with backpressure and multi-tile accumulation, so larger matrices can be tiled as a sum of 2x2 block products.
- Adds a saturating accumulator with an overflow flag, and a matrix-vector mode.
- Sits between the operand tile fetcher and the result writeback in the accelerator datapath.

---
 rtl/strassen_mac2x2.sv | 152 +++++++++++++++
 tb/tb_strassen_mac2x2.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/strassen_mac2x2.sv
// Pipelined 2x2 signed matrix multiply-accumulate built on the 7-product Strassen form.
// Valid/ready handshake with a global stall, saturating tile accumulator and matrix-vector mode.
module strassen_mac2x2 #(
    parameter int DATAWIDTH = 16,
    parameter int ACCWIDTH  = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*DATAWIDTH-1:0]  A,
    input  logic [4*DATAWIDTH-1:0]  B,
    input  logic                    mode,
    input  logic                    acc_first,
    input  logic                    acc_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*ACCWIDTH-1:0]   C,
    output logic                    out_ovf
);
    localparam int DW = DATAWIDTH;
    localparam int EW = DW + 1;
    localparam int MW = 2*DW + 2;
    localparam int CW = 2*DW + 4;
    localparam int SW = ((ACCWIDTH > CW) ? ACCWIDTH : CW) + 1;
    localparam logic signed [SW-1:0] MAXV = {{(SW-ACCWIDTH+1){1'b0}}, {(ACCWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    typedef struct packed {
        logic mode;
        logic first;
        logic last;
    } side_t;

    logic                       stall;
    logic [2:0]                 vld_pipe;
    side_t [2:0]                side_pipe;
    side_t                      side_in;

    logic signed [DW-1:0]       a00, a01, a10, a11, b00, b01, b10, b11;
    logic signed [EW-1:0]       t_s1 [7];
    logic signed [EW-1:0]       s_s1 [7];
    logic signed [MW-1:0]       m_s2 [7];
    logic signed [CW-1:0]       c_s3 [4];

    logic signed [ACCWIDTH-1:0] acc [4];
    logic                       ovf;
    logic signed [SW-1:0]       base [4];
    logic signed [SW-1:0]       sum [4];
    logic signed [ACCWIDTH-1:0] sat [4];
    logic [3:0]                 clip;
    logic                       ovf_nxt;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign side_in  = '{mode: mode, first: acc_first, last: acc_last};

    // Matrix-vector mode replicates B column 0 into column 1 before the products.
    always_comb begin
        a00 = A[DW-1:0];
        a01 = A[2*DW-1:DW];
        a10 = A[3*DW-1:2*DW];
        a11 = A[4*DW-1:3*DW];
        b00 = B[DW-1:0];
        b10 = B[3*DW-1:2*DW];
        b01 = mode ? B[DW-1:0]      : B[2*DW-1:DW];
        b11 = mode ? B[3*DW-1:2*DW] : B[4*DW-1:3*DW];
    end

    // Datapath stages S1..S3 carry no reset; the valid bits decide what is meaningful.
    always_ff @(posedge clk) begin
        if (!stall) begin
            t_s1[0] <= EW'(a00) + EW'(a11);  s_s1[0] <= EW'(b00) + EW'(b11);
            t_s1[1] <= EW'(a10) + EW'(a11);  s_s1[1] <= EW'(b00);
            t_s1[2] <= EW'(a00);             s_s1[2] <= EW'(b01) - EW'(b11);
            t_s1[3] <= EW'(a11);             s_s1[3] <= EW'(b10) - EW'(b00);
            t_s1[4] <= EW'(a00) + EW'(a01);  s_s1[4] <= EW'(b11);
            t_s1[5] <= EW'(a10) - EW'(a00);  s_s1[5] <= EW'(b00) + EW'(b01);
            t_s1[6] <= EW'(a01) - EW'(a11);  s_s1[6] <= EW'(b10) + EW'(b11);

            for (int i = 0; i < 7; i++)
                m_s2[i] <= MW'(t_s1[i]) * MW'(s_s1[i]);
            if (side_pipe[0].mode) begin
                m_s2[0] <= '0;
                m_s2[5] <= '0;
                m_s2[6] <= '0;
            end

            // In matrix-vector mode both columns equal M2+M4 (row 0) and M1+M3 (row 1).
            if (side_pipe[1].mode) begin
                c_s3[0] <= CW'(m_s2[2]) + CW'(m_s2[4]);
                c_s3[1] <= CW'(m_s2[2]) + CW'(m_s2[4]);
                c_s3[2] <= CW'(m_s2[1]) + CW'(m_s2[3]);
                c_s3[3] <= CW'(m_s2[1]) + CW'(m_s2[3]);
            end else begin
                c_s3[0] <= CW'(m_s2[0]) + CW'(m_s2[3]) - CW'(m_s2[4]) + CW'(m_s2[6]);
                c_s3[1] <= CW'(m_s2[2]) + CW'(m_s2[4]);
                c_s3[2] <= CW'(m_s2[1]) + CW'(m_s2[3]);
                c_s3[3] <= CW'(m_s2[0]) - CW'(m_s2[1]) + CW'(m_s2[2]) + CW'(m_s2[5]);
            end
        end
    end

    always_comb begin
        clip = '0;
        for (int i = 0; i < 4; i++) begin
            base[i] = side_pipe[2].first ? '0 : SW'(acc[i]);
            sum[i]  = base[i] + SW'(c_s3[i]);
            if (sum[i] > MAXV) begin
                sat[i]  = MAXV[ACCWIDTH-1:0];
                clip[i] = 1'b1;
            end else if (sum[i] < MINV) begin
                sat[i]  = MINV[ACCWIDTH-1:0];
                clip[i] = 1'b1;
            end else begin
                sat[i]  = sum[i][ACCWIDTH-1:0];
            end
        end
        ovf_nxt = (side_pipe[2].first ? 1'b0 : ovf) | (|clip);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            side_pipe <= '0;
            for (int i = 0; i < 4; i++)
                acc[i] <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            C         <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            vld_pipe  <= {vld_pipe[1:0], in_valid};
            side_pipe <= {side_pipe[1:0], side_in};
            out_valid <= vld_pipe[2] && side_pipe[2].last;
            if (vld_pipe[2]) begin
                if (side_pipe[2].last) begin
                    for (int i = 0; i < 4; i++) begin
                        C[i*ACCWIDTH +: ACCWIDTH] <= sat[i];
                        acc[i] <= '0;
                    end
                    out_ovf <= ovf_nxt;
                    ovf     <= 1'b0;
                end else begin
                    for (int i = 0; i < 4; i++)
                        acc[i] <= sat[i];
                    ovf <= ovf_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_strassen_mac2x2.sv
// Scoreboard bench for strassen_mac2x2: a plain matrix-arithmetic model predicts each
// emitted tile, and a negedge monitor checks results, stall behaviour and in_ready.
module tb_strassen_mac2x2;
    localparam int DW = 16;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4*DW-1:0]   A = '0;
    logic [4*DW-1:0]   B = '0;
    logic              mode = 1'b0;
    logic              acc_first = 1'b0;
    logic              acc_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [4*AW-1:0]   C;
    logic              out_ovf;

    strassen_mac2x2 #(.DATAWIDTH(DW), .ACCWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .mode(mode), .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(out_valid), .out_ready(out_ready), .C(C), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4*AW-1:0] c;
        logic            ovf;
    } exp_t;

    exp_t     exp_q[$];
    int       errors = 0;
    int       checks = 0;
    longint   macc[4];
    bit       movf = 1'b0;
    bit       was_stall = 1'b0;
    logic [4*AW-1:0] c_hold;
    bit       rand_done = 1'b0;

    function automatic logic [4*DW-1:0] tile(input int e00, input int e01, input int e10, input int e11);
        return {16'(e11), 16'(e10), 16'(e01), 16'(e00)};
    endfunction

    function automatic longint elem(input logic [4*DW-1:0] m, input int idx);
        logic signed [DW-1:0] v;
        v = m[idx*DW +: DW];
        return longint'(v);
    endfunction

    // Reference: ordinary row-by-column product, added to the running sum and clamped.
    task automatic model_beat(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                              input logic m, input logic f, input logic l);
        longint lo, hi, p, s;
        exp_t   e;
        hi = (64'sd1 <<< (AW-1)) - 1;
        lo = -(64'sd1 <<< (AW-1));
        if (f) begin
            for (int k = 0; k < 4; k++) macc[k] = 0;
            movf = 1'b0;
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                int jj;
                jj = m ? 0 : j;
                p = elem(a, 2*i) * elem(b, jj) + elem(a, 2*i+1) * elem(b, 2+jj);
                s = macc[2*i+j] + p;
                if (s > hi) begin s = hi; movf = 1'b1; end
                else if (s < lo) begin s = lo; movf = 1'b1; end
                macc[2*i+j] = s;
            end
        if (l) begin
            for (int k = 0; k < 4; k++) e.c[k*AW +: AW] = macc[k][AW-1:0];
            e.ovf = movf;
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) macc[k] = 0;
            movf = 1'b0;
        end
    endtask

    task automatic send(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                        input logic m, input logic f, input logic l);
        int n;
        in_valid = 1'b1; A = a; B = b; mode = m; acc_first = f; acc_last = l;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1 within 200 cycles", in_ready);
        end else begin
            model_beat(a, b, m, f, l);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [4*DW-1:0] rnd_tile();
        logic [4*DW-1:0] t;
        for (int k = 0; k < 4; k++)
            if ($urandom_range(3) == 0) t[k*DW +: DW] = 16'($urandom);
            else t[k*DW +: DW] = 16'(int'($urandom_range(200)) - 100);
        return t;
    endfunction

    // Monitor: consumption checks, hold-while-stalled and in_ready rule.
    always @(negedge clk) begin
        if (!rst) begin
            was_stall <= 1'b0;
        end else begin
            if (was_stall) begin
                chk("stall_c_hold", longint'(C != c_hold), 0);
                chk("stall_valid_hold", longint'(out_valid), 1);
            end
            chk("in_ready_rule", longint'(in_ready), longint'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: C=%h with empty scoreboard", C);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (C !== e.c) begin
                        errors++;
                        $display("FAIL result_c: got %h required %h", C, e.c);
                    end
                    chk("result_ovf", longint'(out_ovf), longint'(e.ovf));
                end
            end
            was_stall <= out_valid && !out_ready;
            c_hold    <= C;
        end
    end

    initial begin
        int n;
        for (int k = 0; k < 4; k++) macc[k] = 0;
        idle(2);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_c_zero", longint'(C != '0), 0);
        chk("reset_out_ovf", longint'(out_ovf), 0);
        chk("reset_in_ready", longint'(in_ready), 1);
        rst = 1'b1;
        idle(2);

        // Directed tiles
        send(tile(1,2,3,4), tile(5,6,7,8), 1'b0, 1'b1, 1'b1);
        idle(5);
        send(tile(1,2,3,4), tile(5,99,7,99), 1'b1, 1'b1, 1'b1);
        idle(5);
        send(tile(1,2,3,4), tile(5,6,7,8), 1'b0, 1'b1, 1'b0);
        idle(1);
        send(tile(1,2,3,4), tile(5,6,7,8), 1'b0, 1'b0, 1'b1);
        send(tile(-1,0,0,-1), tile(3,-4,5,6), 1'b0, 1'b1, 1'b1);
        idle(5);
        send(tile(-32768,-32768,-32768,-32768), tile(-32768,-32768,-32768,-32768), 1'b0, 1'b1, 1'b1);
        send(tile(2,0,0,2), tile(1,1,1,1), 1'b0, 1'b1, 1'b1);
        idle(6);

        // Backpressure: six back-to-back singles, downstream stalls 5 cycles at the first result
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send(tile(k, k+1, -k, 3), tile(2, -k, k+4, 1), k[0], 1'b1, 1'b1);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 100) begin @(negedge clk); n++; end
                chk("bp_first_result_seen", longint'(out_valid), 1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(8);

        // Async reset with a stalled result and a partial sum in flight
        out_ready = 1'b0;
        send(tile(3,1,4,1), tile(5,9,2,6), 1'b0, 1'b1, 1'b1);
        send(tile(100,200,300,400), tile(7,7,7,7), 1'b0, 1'b1, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("pre_reset_valid", longint'(out_valid), 1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", longint'(out_valid), 0);
        chk("async_rst_c", longint'(C != '0), 0);
        chk("async_rst_ovf", longint'(out_ovf), 0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) macc[k] = 0;
        movf = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        send(tile(1,2,3,4), tile(5,6,7,8), 1'b0, 1'b0, 1'b1);
        idle(6);

        // Randomized traffic with random backpressure
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    if ($urandom_range(3) == 0) idle(1);
                    send(rnd_tile(), rnd_tile(), 1'($urandom_range(1)),
                         1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0));
                end
                send(rnd_tile(), rnd_tile(), 1'b0, 1'b0, 1'b1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin idle(1); n++; end
        chk("scoreboard_drained", longint'(exp_q.size()), 0);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
